// File: rtl/adder_result_fifo.sv
// Purpose: first-word-fall-through buffer for adder sums, with drop tracking when full.
// Latency: a pushed entry shows on o_valid/o_data right after its write edge; pops advance on the edge.
// Backpressure: the adder cannot stall, so a push into a full FIFO without a pop is dropped and counted.
module adder_result_fifo #(
  parameter int g_data_width = 8,
  parameter int g_depth      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [g_data_width:0]     i_data,
  output logic                      o_valid,
  output logic [g_data_width:0]     o_data,
  input  logic                      i_ready,
  output logic [$clog2(g_depth):0]  o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_overflow,
  output logic [15:0]               o_drop_cnt,
  input  logic                      i_clr_err
);

  localparam int c_aw = $clog2(g_depth);
  localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(g_depth);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [g_data_width:0] r_mem [g_depth];
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_aw:0]         r_count;
  logic                  r_overflow;
  logic [15:0]           r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status flags are all decoded from the occupancy count.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop   = !w_empty & i_ready;
  assign w_push  = i_valid & (!w_full | w_pop);
  assign w_drop  = i_valid & w_full & !w_pop;

  assign o_valid    = !w_empty;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
  // Head is forced to zero when nothing is stored.
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written on push, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Loss reporting; a drop in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clr_err) begin
      r_overflow <= w_drop;
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo: a per-cycle vector table plus
// hand-written sequences for asynchronous reset and pointer wrap-around.
module tb_adder_result_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [8:0]  i_data;
  logic        o_valid;
  logic [8:0]  o_data;
  logic        i_ready;
  logic [3:0]  o_count;
  logic        o_full;
  logic        o_empty;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;
  logic        i_clr_err;

  int n_checks = 0;
  int n_errors = 0;

  adder_result_fifo #(.g_data_width(8), .g_depth(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt),
    .i_clr_err  (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  // One cycle: inputs applied, then expected state just after the edge.
  typedef struct {
    logic        v;
    logic [8:0]  d;
    logic        r;
    logic        c;
    logic        ev;
    logic [8:0]  ed;
    logic [3:0]  ecnt;
    logic        eovf;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic [8:0] d, input logic r, input logic c,
                         input logic ev, input logic [8:0] ed, input logic [3:0] ecnt,
                         input logic eovf, input logic [15:0] edrop);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.ev = ev; t.ed = ed; t.ecnt = ecnt; t.eovf = eovf; t.edrop = edrop;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic ev, input logic [8:0] ed, input logic [3:0] ecnt,
                           input logic eovf, input logic [15:0] edrop);
    check("valid",    idx, 32'(o_valid),    32'(ev));
    check("data",     idx, 32'(o_data),     32'(ed));
    check("count",    idx, 32'(o_count),    32'(ecnt));
    check("full",     idx, 32'(o_full),     32'(ecnt == 4'd8));
    check("empty",    idx, 32'(o_empty),    32'(ecnt == 4'd0));
    check("overflow", idx, 32'(o_overflow), 32'(eovf));
    check("drop_cnt", idx, 32'(o_drop_cnt), 32'(edrop));
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_clr_err = 1'b0;
  endtask

  initial begin
    // Pass-through: push then pop.
    add_vec(1, 9'h1FE, 1, 0,  1, 9'h1FE, 4'd1, 0, 16'd0);
    add_vec(0, 9'h000, 1, 0,  0, 9'h000, 4'd0, 0, 16'd0);
    // Fill with 1..8, ready low; head stays at 1.
    for (int k = 1; k <= 8; k++)
      add_vec(1, 9'(k), 0, 0,  1, 9'h001, 4'(k), 0, 16'd0);
    // Three drops while full.
    for (int k = 1; k <= 3; k++)
      add_vec(1, 9'(9'h0F0 + k), 0, 0,  1, 9'h001, 4'd8, 1, 16'(k));
    // Clear together with a drop: the drop wins.
    add_vec(1, 9'h055, 0, 1,  1, 9'h001, 4'd8, 1, 16'd1);
    // Plain clear.
    add_vec(0, 9'h000, 0, 1,  1, 9'h001, 4'd8, 0, 16'd0);
    // Full with push+pop: no drop, 1 leaves, 0AA enters at the tail.
    add_vec(1, 9'h0AA, 1, 0,  1, 9'h002, 4'd8, 0, 16'd0);
    // Drain: 2..8 then 0AA.
    for (int k = 1; k <= 6; k++)
      add_vec(0, 9'h000, 1, 0,  1, 9'(k + 2), 4'(8 - k), 0, 16'd0);
    add_vec(0, 9'h000, 1, 0,  1, 9'h0AA, 4'd1, 0, 16'd0);
    add_vec(0, 9'h000, 1, 0,  0, 9'h000, 4'd0, 0, 16'd0);
    // Ready while empty does nothing.
    add_vec(0, 9'h000, 1, 0,  0, 9'h000, 4'd0, 0, 16'd0);

    // Reset state.
    idle_inputs();
    i_rst = 1'b1;
    #12;
    check_all(-1, 0, 9'h000, 4'd0, 0, 16'd0);
    step();
    i_rst = 1'b0;
    step();

    // Table-driven vectors.
    foreach (vecs[i]) begin
      i_valid = vecs[i].v; i_data = vecs[i].d; i_ready = vecs[i].r; i_clr_err = vecs[i].c;
      step();
      check_all(i, vecs[i].ev, vecs[i].ed, vecs[i].ecnt, vecs[i].eovf, vecs[i].edrop);
    end
    idle_inputs();

    // Wrap-around: 20 back-to-back push/pop pairs through the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1; i_data = 9'(9'h100 + 7 * i); i_ready = 1'b1;
      step();
      check("wrap_data", i, 32'(o_data), 32'(9'(9'h100 + 7 * i)));
      check("wrap_count_le1", i, 32'(o_count <= 4'd1), 32'd1);
    end
    i_valid = 1'b0;
    step();
    check("wrap_final_count", 20, 32'(o_count), 32'd0);

    // Asynchronous reset mid-burst with a pending overflow.
    i_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1; i_data = 9'(9'h020 + k);
      step();
    end
    check("pre_rst_overflow", 0, 32'(o_overflow), 32'd1);
    check("pre_rst_count", 0, 32'(o_count), 32'd8);
    i_valid = 1'b1;
    #1;
    i_rst = 1'b1;
    #2;
    check_all(-2, 0, 9'h000, 4'd0, 0, 16'd0);
    idle_inputs();
    step();
    i_rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog against an unexpected hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
